// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  // Widest operand the sign helpers can handle; a product needs 2*WIDTH bits,
  // so WIDTH must stay at or below MAX_W/2.
  localparam int MAX_W = 128;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MULS = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIVS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  // Two's-complement negation when neg is set. Callers zero-extend into
  // MAX_W bits and cast the result back down to the width they need.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                input logic neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

  function automatic logic is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic is_signed_op(input op_e o);
    return o[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned shift-add multiplier or the
// restoring divider. The accumulator is {hi, lo}:
//   MUL: hi = partial product, lo = remaining multiplier bits
//   DIV: hi = partial remainder, lo = dividend bits shifting into quotient
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   sub_diff;

  // Compute the next accumulator for whichever iteration kind is selected.
  always_comb begin
    hi        = acc[2*WIDTH-1:WIDTH];
    lo        = acc[WIDTH-1:0];
    add_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    rem_shift = {hi, lo[WIDTH-1]};
    sub_diff  = rem_shift - {1'b0, operand};
    acc_next  = {add_sum, lo[WIDTH-1:1]};
    if (div_mode) begin
      if (rem_shift >= {1'b0, operand}) begin
        acc_next = {sub_diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_shift[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per clock on magnitudes, sign fix
// in a final cycle, tagged result returned under a valid/ready handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [TAG_W-1:0] res_tag,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int DW    = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e state;
  state_e state_next;

  op_e              op_in;
  op_e              op_q;
  logic [DW-1:0]    acc_q;
  logic [DW-1:0]    acc_step;
  logic [WIDTH-1:0] operand_q;
  logic [WIDTH-1:0] a_raw_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] count_q;
  logic             neg_q;
  logic             neg_r;
  logic             byp_dz_q;
  logic             byp_ovf_q;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic             bypass_dz;
  logic             bypass_ovf;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [DW-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] fix_hi;
  logic             fix_ovf;
  logic             fix_dz;

  assign start_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign res_valid   = (state == S_DONE);

  // Decode the incoming request: operand magnitudes and the two cases that
  // skip iteration entirely (divide by zero, MIN / -1).
  always_comb begin
    op_in      = op_e'(op);
    a_neg      = is_signed_op(op_in) && a[WIDTH-1];
    b_neg      = is_signed_op(op_in) && b[WIDTH-1];
    a_mag      = WIDTH'(cond_neg(MAX_W'(a), a_neg));
    b_mag      = WIDTH'(cond_neg(MAX_W'(b), b_neg));
    bypass_dz  = is_div(op_in) && (b == '0);
    bypass_ovf = (op_in == OP_DIVS) && (a == MIN_VAL) && (b == '1);
    accept     = start_valid && start_ready && !flush;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_step_in()),
    .operand  (operand_q),
    .div_mode (is_div(op_q)),
    .acc_next (acc_step)
  );

  function automatic logic [DW-1:0] acc_step_in();
    return acc_q;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides everything else. Bypassed operations
  // spend their single cycle in FIX, where the special results are loaded.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = (bypass_dz || bypass_ovf) ? S_FIX : S_CALC;
      S_CALC: if (count_q == CNT_W'(1)) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: if (res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // Final sign correction and flag generation from the unsigned accumulator.
  always_comb begin
    prod    = DW'(cond_neg(MAX_W'(acc_q), neg_q));
    quo     = WIDTH'(cond_neg(MAX_W'(acc_q[WIDTH-1:0]), neg_q));
    rem     = WIDTH'(cond_neg(MAX_W'(acc_q[DW-1:WIDTH]), neg_r));
    fix_lo  = '0;
    fix_hi  = '0;
    fix_ovf = 1'b0;
    fix_dz  = 1'b0;
    if (byp_dz_q) begin
      fix_lo = '1;
      fix_hi = a_raw_q;
      fix_dz = 1'b1;
    end else if (byp_ovf_q) begin
      fix_lo  = MIN_VAL;
      fix_ovf = 1'b1;
    end else begin
      case (op_q)
        OP_MULU: begin
          fix_lo  = prod[WIDTH-1:0];
          fix_hi  = prod[DW-1:WIDTH];
          fix_ovf = (prod[DW-1:WIDTH] != '0);
        end
        OP_MULS: begin
          fix_lo  = prod[WIDTH-1:0];
          fix_hi  = prod[DW-1:WIDTH];
          fix_ovf = (prod[DW-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
        end
        default: begin
          fix_lo = quo;
          fix_hi = rem;
        end
      endcase
    end
  end

  // Operand capture on accept, one iteration per CALC cycle, and result
  // registers loaded in FIX so they hold steady throughout DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= OP_MULU;
      acc_q       <= '0;
      operand_q   <= '0;
      a_raw_q     <= '0;
      tag_q       <= '0;
      count_q     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      byp_dz_q    <= 1'b0;
      byp_ovf_q   <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      res_tag     <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= op_in;
        acc_q     <= {{WIDTH{1'b0}}, (is_div(op_in) ? a_mag : b_mag)};
        operand_q <= is_div(op_in) ? b_mag : a_mag;
        a_raw_q   <= a;
        tag_q     <= rd_tag;
        count_q   <= CNT_W'(WIDTH);
        neg_q     <= a_neg ^ b_neg;
        neg_r     <= a_neg;
        byp_dz_q  <= bypass_dz;
        byp_ovf_q <= bypass_ovf && !bypass_dz;
      end else if (state == S_CALC) begin
        acc_q   <= acc_step;
        count_q <= count_q - CNT_W'(1);
      end else if (state == S_FIX && !flush) begin
        result      <= fix_lo;
        result_hi   <= fix_hi;
        res_tag     <= tag_q;
        div_by_zero <= fix_dz;
        overflow    <= fix_ovf;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a reference-model scoreboard.
module tb_muldiv_unit;

  localparam int WIDTH = 16;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  tag;
    logic        dz;
    logic        ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             start_valid = 1'b0;
  logic             res_ready = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [TAG_W-1:0] rd_tag = '0;
  logic             start_ready;
  logic             res_valid;
  logic             div_by_zero;
  logic             overflow;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [TAG_W-1:0] res_tag;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  muldiv_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .rd_tag      (rd_tag),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .result_hi   (result_hi),
    .res_tag     (res_tag),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .busy        (busy)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Reference model built on native wide integer arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [15:0] x,
                                 input logic [15:0] y, input logic [3:0] t);
    exp_t   e;
    longint sx, sy, p, q, r;
    e     = '0;
    e.tag = t;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    case (o)
      2'b00: begin
        p     = longint'(x) * longint'(y);
        e.lo  = p[15:0];
        e.hi  = p[31:16];
        e.ovf = (p > 64'sd65535);
      end
      2'b01: begin
        p     = sx * sy;
        e.lo  = p[15:0];
        e.hi  = p[31:16];
        e.ovf = (p > 64'sd32767) || (p < -64'sd32768);
      end
      2'b10: begin
        if (y == 16'h0) begin
          e.lo = 16'hFFFF; e.hi = x; e.dz = 1'b1;
        end else begin
          q = longint'(x) / longint'(y);
          r = longint'(x) % longint'(y);
          e.lo = q[15:0]; e.hi = r[15:0];
        end
      end
      default: begin
        if (y == 16'h0) begin
          e.lo = 16'hFFFF; e.hi = x; e.dz = 1'b1;
        end else if (x == 16'h8000 && y == 16'hFFFF) begin
          e.lo = 16'h8000; e.hi = 16'h0000; e.ovf = 1'b1;
        end else begin
          q = sx / sy;
          r = sx % sy;
          e.lo = q[15:0]; e.hi = r[15:0];
        end
      end
    endcase
    return e;
  endfunction

  function automatic int expLatency(input logic [1:0] o, input logic [15:0] x,
                                    input logic [15:0] y);
    if (o[1] && y == 16'h0) return 1;
    if (o == 2'b11 && x == 16'h8000 && y == 16'hFFFF) return 1;
    return WIDTH + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    checkOutput({tag, "_busy"},        32'(busy),        32'd0);
    checkOutput({tag, "_res_valid"},   32'(res_valid),   32'd0);
    checkOutput({tag, "_result"},      32'(result),      32'd0);
    checkOutput({tag, "_result_hi"},   32'(result_hi),   32'd0);
    checkOutput({tag, "_res_tag"},     32'(res_tag),     32'd0);
    checkOutput({tag, "_dz"},          32'(div_by_zero), 32'd0);
    checkOutput({tag, "_ovf"},         32'(overflow),    32'd0);
  endtask

  // Called just after a falling edge; the request is accepted on the next
  // rising edge and the task returns at the falling edge after it.
  task automatic applyStimulus(input logic [1:0] o, input logic [15:0] x,
                               input logic [15:0] y, input logic [3:0] t,
                               input bit keep);
    op = o; a = x; b = y; rd_tag = t;
    start_valid = 1'b1;
    checkOutput("issue_start_ready", 32'(start_ready), 32'd1);
    if (keep) sb.push_back(model(o, x, y, t));
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  // Counts rising edges since accept until res_valid, then pops and compares.
  task automatic waitResult(input int exp_lat, input string tag, output exp_t e);
    int lat;
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checkOutput({tag, "_res_valid"}, 32'(res_valid),   32'd1);
    checkOutput({tag, "_result"},    32'(result),      32'(e.lo));
    checkOutput({tag, "_result_hi"}, 32'(result_hi),   32'(e.hi));
    checkOutput({tag, "_res_tag"},   32'(res_tag),     32'(e.tag));
    checkOutput({tag, "_dz"},        32'(div_by_zero), 32'(e.dz));
    checkOutput({tag, "_ovf"},       32'(overflow),    32'(e.ovf));
  endtask

  task automatic completeHandshake(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput({tag, "_post_valid"}, 32'(res_valid),   32'd0);
    checkOutput({tag, "_post_ready"}, 32'(start_ready), 32'd1);
  endtask

  task automatic runOp(input logic [1:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic [3:0] t, input string tag);
    exp_t e;
    applyStimulus(o, x, y, t, 1'b1);
    waitResult(expLatency(o, x, y), tag, e);
    completeHandshake(tag);
  endtask

  // Directed sequence: reset, test-plan operations, random ops, back-pressure,
  // flush and mid-operation reset.
  initial begin
    exp_t        e;
    logic [1:0]  ro;
    logic [15:0] rx, ry;

    repeat (2) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    @(negedge clk);

    runOp(2'b00, 16'h00FF, 16'h0101, 4'h3, "mulu_basic");
    runOp(2'b01, 16'hFFFD, 16'h0007, 4'h5, "muls_neg");
    runOp(2'b00, 16'h0100, 16'h0100, 4'h6, "mulu_ovf");
    runOp(2'b11, 16'hFFF9, 16'h0002, 4'h7, "divs_neg");
    runOp(2'b10, 16'hFFF9, 16'h0002, 4'h8, "divu_big");
    runOp(2'b10, 16'h1234, 16'h0000, 4'h9, "divu_zero");
    runOp(2'b11, 16'h8000, 16'hFFFF, 4'hA, "divs_minneg1");
    runOp(2'b11, 16'h0007, 16'hFFFE, 4'hB, "divs_posneg");

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = 16'($urandom);
      ry = 16'($urandom);
      runOp(ro, rx, ry, 4'(i), "random");
    end

    // Result held under back-pressure while further requests are offered.
    applyStimulus(2'b01, 16'h7FFF, 16'h0002, 4'hC, 1'b1);
    waitResult(WIDTH + 1, "bp", e);
    for (int i = 0; i < 5; i++) begin
      op = 2'b00; a = 16'h1111; b = 16'h2222; rd_tag = 4'h0;
      start_valid = 1'b1;
      @(negedge clk);
      checkOutput("bp_hold_valid",  32'(res_valid),   32'd1);
      checkOutput("bp_hold_result", 32'(result),      32'(e.lo));
      checkOutput("bp_hold_hi",     32'(result_hi),   32'(e.hi));
      checkOutput("bp_hold_tag",    32'(res_tag),     32'(e.tag));
      checkOutput("bp_hold_ovf",    32'(overflow),    32'(e.ovf));
      checkOutput("bp_start_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    completeHandshake("bp");

    // Flush wins over a simultaneous start request.
    op = 2'b00; a = 16'h0003; b = 16'h0004;
    start_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    start_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_prio_busy", 32'(busy), 32'd0);

    // Flush on the sixth edge of a DIVU, then a fresh op must complete.
    applyStimulus(2'b10, 16'hABCD, 16'h0013, 4'h1, 1'b0);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_res_valid",   32'(res_valid),   32'd0);
    checkOutput("flush_busy",        32'(busy),        32'd0);
    checkOutput("flush_start_ready", 32'(start_ready), 32'd1);
    runOp(2'b10, 16'hABCD, 16'h0013, 4'h2, "after_flush");

    // Reset asserted in the middle of CALC clears outputs at once.
    applyStimulus(2'b00, 16'h1234, 16'h5678, 4'h4, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("calc_busy",        32'(busy),        32'd1);
    checkOutput("calc_start_ready", 32'(start_ready), 32'd0);
    reset = 1'b1;
    #1;
    checkResetValues("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    runOp(2'b01, 16'h8000, 16'h8000, 4'hF, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
